// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared FSM encodings and default sizes for the APB completer
//
// Purpose: state encoding and default geometry shared by apb_slave_mem and
//          its wait-state counter.
// Ports:   none (package).
package apb_pkg;

  localparam int APB_ADDR_WIDTH  = 4;
  localparam int APB_DATA_WIDTH  = 8;
  localparam int APB_DEPTH       = 12;
  localparam int WAIT_CTR_WIDTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_wait_ctr.sv
// rtl/apb_wait_ctr.sv - loadable down-counter timing the APB wait states
//
// Purpose: holds the remaining wait-state count for the current transfer and
//          flags the cycle in which it reaches its last wait state.
// Ports:
//   Clk       in   system clock
//   Reset     in   synchronous active-high reset
//   load      in   load load_val (setup phase)
//   load_val  in   wait-state count to load
//   dec       in   decrement by one (saturates at zero)
//   last      out  count == 1, i.e. the final wait cycle
module apb_wait_ctr
  import apb_pkg::*;
#(
  parameter int WIDTH = WAIT_CTR_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer serving a small register file with wait states
//
// Purpose: decodes APB setup/access phases, inserts WAIT_STATES wait cycles,
//          then completes the transfer against an internal DEPTH-word memory.
//          Addresses at or above DEPTH answer with Pslverr.
// Ports:
//   Clk      in   system clock
//   Reset    in   synchronous active-high reset
//   Psel     in   slave select
//   Penable  in   access-phase strobe
//   Pwrite   in   1 = write, 0 = read
//   Paddr    in   word address
//   Pwdata   in   write data
//   Prdata   out  read data, valid while Pready
//   Pready   out  transfer completion (registered, one cycle)
//   Pslverr  out  error response (registered, valid with Pready)
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int DEPTH       = APB_DEPTH,
  parameter int WAIT_STATES = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Psel,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_WIDTH-1:0] Paddr,
  input  logic [DATA_WIDTH-1:0] Pwdata,
  output logic [DATA_WIDTH-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);

  localparam logic [ADDR_WIDTH:0]         DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [WAIT_CTR_WIDTH-1:0]   WS_VAL  = WAIT_CTR_WIDTH'(WAIT_STATES);

  apb_state_e state_q, state_d;

  logic                  addr_q_write;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic setup;
  logic load;
  logic wait_last;
  logic enter_ready;
  logic addr_oor;

  // Values for the transfer about to enter READY. With zero wait states the
  // setup edge is also the READY-entry edge, so the live bus is used there.
  logic                  cur_err;
  logic                  cur_write;
  logic [ADDR_WIDTH-1:0] cur_addr;

  assign setup    = Psel && !Penable;
  assign addr_oor = ({1'b0, Paddr} >= DEPTH_L);
  assign load     = (state_q == ST_IDLE) && setup;

  assign cur_err   = load ? addr_oor : err_q;
  assign cur_write = load ? Pwrite   : addr_q_write;
  assign cur_addr  = load ? Paddr    : addr_q;

  apb_wait_ctr #(
    .WIDTH(WAIT_CTR_WIDTH)
  ) u_wait_ctr (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (load),
    .load_val (WS_VAL),
    .dec      (state_q == ST_WAIT),
    .last     (wait_last)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_READY;
        end
      end
      ST_WAIT: begin
        if (!Psel) begin
          state_d = ST_IDLE;
        end else if (wait_last) begin
          state_d = ST_READY;
        end
      end
      ST_READY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // READY always exits to IDLE, so a READY next state means READY entry.
  assign enter_ready = (state_d == ST_READY);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Prdata       <= '0;
      Pready       <= 1'b0;
      Pslverr      <= 1'b0;
      addr_q       <= '0;
      addr_q_write <= 1'b0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (load) begin
        addr_q       <= Paddr;
        addr_q_write <= Pwrite;
        wdata_q      <= Pwdata;
        err_q        <= addr_oor;
      end

      Pready  <= enter_ready;
      Pslverr <= enter_ready && cur_err;

      if (enter_ready && !cur_write) begin
        Prdata <= cur_err ? '0 : mem[cur_addr];
      end

      // Commit at the edge closing READY, only if the master kept the access.
      if ((state_q == ST_READY) && Psel && Penable && addr_q_write && !err_q) begin
        mem[addr_q] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed self-checking bench for apb_slave_mem
module tb_apb_slave_mem;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       psel;
  logic       use0;
  logic       Psel1, Psel0;
  logic       Penable;
  logic       Pwrite;
  logic [3:0] Paddr;
  logic [7:0] Pwdata;
  logic [7:0] Prdata1, Prdata0;
  logic       Pready1, Pready0;
  logic       Pslverr1, Pslverr0;
  logic       cur_rdy, cur_err;
  logic [7:0] cur_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  assign Psel1     = psel & ~use0;
  assign Psel0     = psel & use0;
  assign cur_rdy   = use0 ? Pready0   : Pready1;
  assign cur_err   = use0 ? Pslverr0  : Pslverr1;
  assign cur_rdata = use0 ? Prdata0   : Prdata1;

  apb_slave_mem #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(12), .WAIT_STATES(1)
  ) dut1 (
    .Clk(Clk), .Reset(Reset), .Psel(Psel1), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata1), .Pready(Pready1), .Pslverr(Pslverr1)
  );

  apb_slave_mem #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(12), .WAIT_STATES(0)
  ) dut0 (
    .Clk(Clk), .Reset(Reset), .Psel(Psel0), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata0), .Pready(Pready0), .Pslverr(Pslverr0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer; returns in the Pready cycle with the bus still in access.
  task automatic xfer(input string tag, input bit wr, input logic [3:0] a,
                      input logic [7:0] d, input int exp_lat, input logic exp_err,
                      output logic [7:0] rd);
    int lat;
    bit got;
    @(negedge Clk);
    check({tag, "_prev_pready_low"}, cur_rdy, 0);
    psel = 1'b1; Penable = 1'b0; Pwrite = wr; Paddr = a; Pwdata = d;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge Clk);
      lat++;
      Penable = 1'b1;
      Paddr   = a ^ 4'h1;
      Pwdata  = ~d;
      if (cur_rdy) got = 1'b1;
    end
    check({tag, "_ready_seen"}, got, 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_slverr"}, cur_err, exp_err);
    rd = cur_rdata;
  endtask

  task automatic go_idle();
    @(negedge Clk);
    check("idle_pready_low", cur_rdy, 0);
    psel = 1'b0; Penable = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] wdat [10];

    Reset = 1'b1; psel = 1'b1; use0 = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = 4'd5; Pwdata = 8'h00;

    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("rst_pready", Pready1, 0);
      check("rst_pslverr", Pslverr1, 0);
      check("rst_prdata", Prdata1, 0);
    end
    Reset = 1'b0; psel = 1'b0;

    xfer("rd5_after_rst", 1'b0, 4'd5, 8'h00, 2, 1'b0, rd);
    check("rd5_data", rd, 8'h00);

    xfer("wr3", 1'b1, 4'd3, 8'hA5, 2, 1'b0, rd);
    xfer("rd3", 1'b0, 4'd3, 8'h00, 2, 1'b0, rd);
    check("rd3_data", rd, 8'hA5);

    xfer("wr11", 1'b1, 4'd11, 8'h77, 2, 1'b0, rd);
    xfer("wr13_oor", 1'b1, 4'd13, 8'h5A, 2, 1'b1, rd);
    xfer("rd13_oor", 1'b0, 4'd13, 8'h00, 2, 1'b1, rd);
    check("rd13_data", rd, 8'h00);
    xfer("rd11", 1'b0, 4'd11, 8'h00, 2, 1'b0, rd);
    check("rd11_data", rd, 8'h77);
    go_idle();

    use0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wdat[i] = 8'($urandom_range(0, 255));
      xfer("ws0_wr", 1'b1, 4'(i), wdat[i], 1, 1'b0, rd);
    end
    for (int i = 0; i < 10; i++) begin
      xfer("ws0_rd", 1'b0, 4'(i), 8'h00, 1, 1'b0, rd);
      check("ws0_rd_data", rd, wdat[i]);
    end
    go_idle();
    use0 = 1'b0;

    xfer("wr2_old", 1'b1, 4'd2, 8'h3C, 2, 1'b0, rd);
    go_idle();
    @(negedge Clk);
    psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 4'd2; Pwdata = 8'hFF;
    @(negedge Clk);
    check("abort_wait_pready", Pready1, 0);
    psel = 1'b0; Penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("abort_no_pready", Pready1, 0);
    end
    xfer("rd2_after_abort", 1'b0, 4'd2, 8'h00, 2, 1'b0, rd);
    check("rd2_data", rd, 8'h3C);
    go_idle();

    @(negedge Clk);
    psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 4'd7; Pwdata = 8'h99;
    @(negedge Clk);
    Penable = 1'b1;
    Reset = 1'b1;
    @(negedge Clk);
    check("midrst_pready", Pready1, 0);
    Reset = 1'b0; psel = 1'b0; Penable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check("midrst_no_pready", Pready1, 0);
    end
    xfer("rd7_after_rst", 1'b0, 4'd7, 8'h00, 2, 1'b0, rd);
    check("rd7_data", rd, 8'h00);
    xfer("rd3_after_rst", 1'b0, 4'd3, 8'h00, 2, 1'b0, rd);
    check("rd3_cleared", rd, 8'h00);
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
